// File: rtl/calc_pkg.sv
// rtl/calc_pkg.sv - key codes, 16-entry keymap and scan-state encoding shared by the calculator front end
package calc_pkg;

    localparam logic [3:0] KEY_ADD = 4'ha;
    localparam logic [3:0] KEY_SUB = 4'hb;
    localparam logic [3:0] KEY_MUL = 4'hc;
    localparam logic [3:0] KEY_DIV = 4'hd;
    localparam logic [3:0] KEY_EQ  = 4'he;
    localparam logic [3:0] KEY_CLR = 4'hf;

    // Indexed by k = 4*row + col; entry 0 is the least significant nibble.
    localparam logic [15:0][3:0] KEYMAP = {
        KEY_DIV, KEY_EQ, 4'h0, KEY_CLR,
        KEY_MUL, 4'h9,   4'h8, 4'h7,
        KEY_SUB, 4'h6,   4'h5, 4'h4,
        KEY_ADD, 4'h3,   4'h2, 4'h1
    };

    typedef enum logic [1:0] {
        ST_SCAN     = 2'd0,
        ST_DEBOUNCE = 2'd1,
        ST_HELD     = 2'd2,
        ST_RELEASE  = 2'd3
    } scan_state_t;

    // Lowest-index low column wins when several are pressed on one row.
    function automatic logic [1:0] lowest_low_col(input logic [3:0] cols_n);
        logic [1:0] col;
        col = 2'd3;
        if (!cols_n[2]) col = 2'd2;
        if (!cols_n[1]) col = 2'd1;
        if (!cols_n[0]) col = 2'd0;
        return col;
    endfunction

    function automatic logic [3:0] key_code(input logic [1:0] row, input logic [1:0] col);
        return KEYMAP[{row, col}];
    endfunction

endpackage

// File: rtl/key_sync.sv
// rtl/key_sync.sv - 4-bit two-flop synchroniser for the keypad column returns, resets to all-ones
module key_sync (
    input  logic       CLK_1K,
    input  logic       RST,
    input  logic [3:0] din,
    output logic [3:0] dout
);

    logic [3:0] meta;

    always_ff @(posedge CLK_1K) begin
        if (RST) begin
            meta <= 4'b1111;
            dout <= 4'b1111;
        end else begin
            meta <= din;
            dout <= meta;
        end
    end

endmodule

// File: rtl/key_scan.sv
// rtl/key_scan.sv - 4x4 keypad scanner/debouncer with one flag per accepted press; define KEY_SCAN_REPEAT_EN for auto-repeat
module key_scan
    import calc_pkg::*;
#(
    parameter int ROW_DWELL     = 4,
    parameter int DEBOUNCE      = 20,
    parameter int REPEAT_DELAY  = 500,
    parameter int REPEAT_PERIOD = 100
) (
    input  logic       CLK_1K,
    input  logic       RST,
    input  logic [3:0] col_n,
    output logic [3:0] row_n,
    output logic [3:0] key_value,
    output logic       flag,
    output logic       key_down
);

    localparam int DWELL_W = (ROW_DWELL > 2) ? $clog2(ROW_DWELL) : 1;
    localparam int DEB_W   = (DEBOUNCE > 2) ? $clog2(DEBOUNCE) : 1;
    localparam logic [DWELL_W-1:0] DWELL_LAST = DWELL_W'(ROW_DWELL - 1);
    localparam logic [DEB_W-1:0]   DEB_LAST   = DEB_W'(DEBOUNCE - 2);

    if (ROW_DWELL < 3 || DEBOUNCE < 2 || REPEAT_PERIOD < 2 || REPEAT_PERIOD > REPEAT_DELAY) begin : g_bad_params
        $error("key_scan: parameter out of range");
    end

    scan_state_t          state;
    scan_state_t          state_nxt;
    logic [3:0]           col_s;
    logic                 row_en;
    logic [1:0]           row_idx;
    logic [1:0]           lat_col;
    logic [1:0]           low_col;
    logic [DWELL_W-1:0]   dwell_cnt;
    logic [DEB_W-1:0]     deb_cnt;
    logic                 any_low;
    logic                 all_high;
    logic                 col_match;
    logic                 lat_low;
    logic                 sample;
    logic                 deb_done;
    logic                 accept;
    logic                 rep_fire;

    key_sync u_sync (
        .CLK_1K (CLK_1K),
        .RST    (RST),
        .din    (col_n),
        .dout   (col_s)
    );

    assign any_low   = ~&col_s;
    assign all_high  = &col_s;
    assign low_col   = lowest_low_col(col_s);
    assign col_match = any_low && (low_col == lat_col);
    assign lat_low   = ~col_s[lat_col];
    // The first two cycles of a dwell still see the previous row through the synchroniser.
    assign sample    = (state == ST_SCAN) && row_en && (dwell_cnt == DWELL_LAST);
    assign deb_done  = (deb_cnt == DEB_LAST);

    always_ff @(posedge CLK_1K) begin
        if (RST) begin
            state <= ST_SCAN;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        accept    = 1'b0;
        case (state)
            ST_SCAN: begin
                if (sample && any_low) begin
                    state_nxt = ST_DEBOUNCE;
                end
            end
            ST_DEBOUNCE: begin
                if (!col_match) begin
                    state_nxt = ST_SCAN;
                end else if (deb_done) begin
                    state_nxt = ST_HELD;
                    accept    = 1'b1;
                end
            end
            ST_HELD: begin
                if (all_high) begin
                    state_nxt = ST_RELEASE;
                end
            end
            ST_RELEASE: begin
                if (lat_low) begin
                    state_nxt = ST_HELD;
                end else if (all_high && deb_done) begin
                    state_nxt = ST_SCAN;
                end
            end
            default: state_nxt = ST_SCAN;
        endcase
    end

    always_comb begin
        key_down = (state == ST_HELD) || (state == ST_RELEASE);
        row_n    = 4'b1111;
        if (row_en) begin
            row_n[row_idx] = 1'b0;
        end
    end

    // The sample cycle itself is the first of the DEBOUNCE matching samples, hence DEB_LAST = DEBOUNCE-2.
    always_ff @(posedge CLK_1K) begin
        if (RST) begin
            row_en    <= 1'b0;
            row_idx   <= 2'd0;
            dwell_cnt <= '0;
            lat_col   <= 2'd0;
            deb_cnt   <= '0;
            key_value <= 4'h0;
            flag      <= 1'b0;
        end else begin
            row_en <= 1'b1;
            flag   <= accept || rep_fire;
            if (accept) begin
                key_value <= key_code(row_idx, lat_col);
            end
            case (state)
                ST_SCAN: begin
                    if (row_en) begin
                        if (sample) begin
                            dwell_cnt <= '0;
                            if (any_low) begin
                                lat_col <= low_col;
                                deb_cnt <= '0;
                            end else begin
                                row_idx <= row_idx + 2'd1;
                            end
                        end else begin
                            dwell_cnt <= dwell_cnt + DWELL_W'(1);
                        end
                    end
                end
                ST_DEBOUNCE: begin
                    if (!col_match) begin
                        deb_cnt   <= '0;
                        dwell_cnt <= '0;
                        row_idx   <= row_idx + 2'd1;
                    end else if (deb_done) begin
                        deb_cnt <= '0;
                    end else begin
                        deb_cnt <= deb_cnt + DEB_W'(1);
                    end
                end
                ST_HELD: begin
                    deb_cnt <= '0;
                end
                ST_RELEASE: begin
                    if (lat_low || !all_high) begin
                        deb_cnt <= '0;
                    end else if (deb_done) begin
                        deb_cnt   <= '0;
                        dwell_cnt <= '0;
                        row_idx   <= 2'd0;
                    end else begin
                        deb_cnt <= deb_cnt + DEB_W'(1);
                    end
                end
                default: deb_cnt <= '0;
            endcase
        end
    end

`ifdef KEY_SCAN_REPEAT_EN
    localparam int REP_W = $clog2(REPEAT_DELAY + 1);
    localparam logic [REP_W-1:0] REP_LAST   = REP_W'(REPEAT_DELAY - 1);
    localparam logic [REP_W-1:0] REP_RELOAD = REP_W'(REPEAT_DELAY - REPEAT_PERIOD);

    logic [REP_W-1:0] rep_cnt;

    // Counts HELD cycles since acceptance; reloading after each repeat yields the period spacing.
    always_ff @(posedge CLK_1K) begin
        if (RST || state == ST_SCAN || accept) begin
            rep_cnt <= '0;
        end else if (state == ST_HELD) begin
            rep_cnt <= rep_fire ? REP_RELOAD : rep_cnt + REP_W'(1);
        end
    end

    assign rep_fire = (state == ST_HELD) && (rep_cnt == REP_LAST);
`else
    assign rep_fire = 1'b0;
`endif

endmodule
